anode_scanner: RTL and testbench

//   Time-multiplexing controller for the 4-digit seven-segment display.

---
 rtl/anode_scanner_if.sv | 25 ++
 rtl/anode_scanner.sv | 91 +++++++++
 tb/tb_anode_scanner.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/anode_scanner_if.sv
// Digit-scan bus between the display controller and the anode scanner.
// The master drives enable/digit mask; the scanner (slave) returns index, anodes and strobe.
interface anode_scanner_if;
    logic       enable;
    logic [3:0] digit_en;
    logic [1:0] anode_index;
    logic [3:0] anode;
    logic       digit_strobe;

    modport master (
        output enable,
        output digit_en,
        input  anode_index,
        input  anode,
        input  digit_strobe
    );

    modport slave (
        input  enable,
        input  digit_en,
        output anode_index,
        output anode,
        output digit_strobe
    );
endinterface

// File: rtl/anode_scanner.sv
// Time-multiplexed anode scanner for a 4-digit seven-segment display.
// Drives each digit for REFRESH_DIV cycles with a BLANK_CYCLES all-off gap between slots.
module anode_scanner #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000,
    parameter int CNT_W        = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    anode_scanner_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_BLANK
    } state_t;

    localparam bit              HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    // Clamped so a zero-length blank never produces a negative constant.
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_index;
    logic             r_strobe;
    logic [3:0]       w_anode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_index  <= '0;
            r_strobe <= 1'b0;
        end else if (!bus.enable) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_index  <= '0;
            r_strobe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state  <= S_DRIVE;
                    r_cnt    <= '0;
                    r_index  <= '0;
                    r_strobe <= 1'b1;
                end
                S_DRIVE: begin
                    if (r_cnt == DRIVE_LAST) begin
                        // Index advances into the blank gap so the mux settles before drive.
                        r_state  <= HAS_BLANK ? S_BLANK : S_DRIVE;
                        r_cnt    <= '0;
                        r_index  <= r_index + 2'd1;
                        r_strobe <= 1'b1;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
                        r_strobe <= 1'b0;
                    end
                end
                S_BLANK: begin
                    r_strobe <= 1'b0;
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= S_DRIVE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= '0;
                    r_index  <= '0;
                    r_strobe <= 1'b0;
                end
            endcase
        end
    end

    // Mask is applied combinationally so digit_en changes are visible in the same cycle.
    always_comb begin
        w_anode = '1;
        if (r_state == S_DRIVE && bus.digit_en[r_index])
            w_anode = ~(4'b0001 << r_index);
    end

    assign bus.anode        = w_anode;
    assign bus.anode_index  = r_index;
    assign bus.digit_strobe = r_strobe;

endmodule

// File: tb/tb_anode_scanner.sv
// Randomized scoreboard bench for anode_scanner: one DUT with a blank gap, one without.
module tb_anode_scanner;

    localparam int R  = 4;
    localparam int B0 = 2;
    localparam int B1 = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] den;

    always #5 clk = ~clk;

    anode_scanner_if u_if0 ();
    anode_scanner_if u_if1 ();

    assign u_if0.enable   = en;
    assign u_if0.digit_en = den;
    assign u_if1.enable   = en;
    assign u_if1.digit_en = den;

    anode_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B0), .CNT_W(3)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if0)
    );

    anode_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B1), .CNT_W(3)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1)
    );

    typedef struct {
        logic [1:0] idx0;
        logic [3:0] an0;
        logic       st0;
        logic [1:0] idx1;
        logic [3:0] an1;
        logic       st1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 0;

    // Reference: p counts cycles since the scan started; slot position follows from p.
    function automatic void model(input bit act, input int p, input int b, input logic [3:0] mask,
                                  output logic [1:0] idx, output logic [3:0] an, output logic st);
        int         per;
        logic [3:0] one;
        per = R + b;
        one = 4'b0001;
        if (!act) begin
            idx = 2'd0;
            an  = 4'hF;
            st  = 1'b0;
        end else begin
            idx = 2'(((p + b) / per) % 4);
            st  = (p == 0) || (p >= R && ((p - R) % per) == 0);
            an  = ((p % per) < R && mask[idx]) ? ~(one << idx) : 4'hF;
        end
    endfunction

    task automatic check_now(input string name, input bit act, input int p);
        logic [1:0] i0, i1;
        logic [3:0] a0, a1;
        logic       s0, s1;
        model(act, p, B0, den, i0, a0, s0);
        model(act, p, B1, den, i1, a1, s1);
        n_vec++;
        if (u_if0.anode !== a0 || u_if0.anode_index !== i0 || u_if0.digit_strobe !== s0 ||
            u_if1.anode !== a1 || u_if1.anode_index !== i1 || u_if1.digit_strobe !== s1) begin
            n_err++;
            $display("FAIL %s t=%0t: got an0=%h idx0=%0d st0=%0b an1=%h idx1=%0d st1=%0b, want an0=%h idx0=%0d st0=%0b an1=%h idx1=%0d st1=%0b",
                     name, $time, u_if0.anode, u_if0.anode_index, u_if0.digit_strobe,
                     u_if1.anode, u_if1.anode_index, u_if1.digit_strobe, a0, i0, s0, a1, i1, s1);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare just after each edge.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (u_if0.anode !== e.an0 || u_if0.anode_index !== e.idx0 || u_if0.digit_strobe !== e.st0 ||
                    u_if1.anode !== e.an1 || u_if1.anode_index !== e.idx1 || u_if1.digit_strobe !== e.st1) begin
                    n_err++;
                    $display("FAIL scan t=%0t: got an0=%h idx0=%0d st0=%0b an1=%h idx1=%0d st1=%0b, want an0=%h idx0=%0d st0=%0b an1=%h idx1=%0d st1=%0b",
                             $time, u_if0.anode, u_if0.anode_index, u_if0.digit_strobe,
                             u_if1.anode, u_if1.anode_index, u_if1.digit_strobe,
                             e.an0, e.idx0, e.st0, e.an1, e.idx1, e.st1);
                end
            end
        end
    end

    initial begin
        bit   act = 0;
        int   p   = 0;
        int   off = 0;
        exp_t e;

        rst_n = 1'b0;
        en    = 1'($urandom);
        den   = 4'($urandom);
        #2;
        check_now("reset_async", 0, 0);
        repeat (2) @(negedge clk);

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (cyc == 420) begin
                // Mid-scan async reset: outputs must clear without a clock edge.
                rst_n = 1'b0;
                en    = 1'($urandom);
                #1;
                act = 0;
                check_now("reset_mid", 0, 0);
                @(negedge clk);
                check_now("reset_hold", 0, 0);
            end
            rst_n = 1'b1;
            if (off > 0) begin
                en = 1'b0;
                off--;
            end else if ($urandom_range(0, 39) == 0) begin
                en  = 1'b0;
                off = $urandom_range(0, 2);
            end else begin
                en = 1'b1;
            end
            if (cyc < 60)
                den = 4'hF;
            else if (cyc < 120)
                den = 4'b1010;
            else if ($urandom_range(0, 7) == 0)
                den = 4'($urandom);

            if (!en)
                act = 0;
            else if (!act) begin
                act = 1;
                p   = 0;
            end else
                p++;

            model(act, p, B0, den, e.idx0, e.an0, e.st0);
            model(act, p, B1, den, e.idx1, e.an1, e.st1);
            q.push_back(e);

            if (cyc % 37 == 20) begin
                // Mask change between edges must reach the anodes immediately.
                @(posedge clk);
                #3;
                den = 4'($urandom);
                #1;
                check_now("mask_comb", act, p);
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
